// File: rtl/pulse_ctrl_pkg.sv
// Shared definitions for the pulse controller result path.
package pulse_ctrl_pkg;

  localparam int unsigned SRC_DDS      = 0;
  localparam int unsigned SRC_SPI      = 1;
  localparam int unsigned SRC_LOOPBACK = 2;
  localparam int unsigned N_RESULT_SRC = 3;
  localparam int unsigned DROP_W       = 16;
  localparam int unsigned RESULT_WIDTH = 32;

  typedef enum logic {
    ARB_IDLE,
    ARB_WRITE
  } arb_state_t;

endpackage

// File: rtl/result_arbiter_if.sv
// Source request/data bus and rFIFO write port shared by the result arbiter.
interface result_arbiter_if
  import pulse_ctrl_pkg::*;
#(
  parameter int unsigned N_SRC        = N_RESULT_SRC,
  parameter int unsigned RESULT_WIDTH = pulse_ctrl_pkg::RESULT_WIDTH
) ();

  logic [N_SRC-1:0]              src_WrReq;
  logic [N_SRC*RESULT_WIDTH-1:0] src_data;
  logic                          rFIFO_full;
  logic [RESULT_WIDTH-1:0]       rFIFO_data;
  logic                          rFIFO_WrReq;

  // Producers and the rFIFO side
  modport master (
    output src_WrReq, src_data, rFIFO_full,
    input  rFIFO_data, rFIFO_WrReq
  );

  // Arbiter side
  modport slave (
    input  src_WrReq, src_data, rFIFO_full,
    output rFIFO_data, rFIFO_WrReq
  );

endinterface

// File: rtl/result_slot.sv
// Per-source capture slot: rising-edge detect, holding register,
// pending flag and sticky overflow with saturating drop counter.
module result_slot
  import pulse_ctrl_pkg::*;
#(
  parameter int unsigned RESULT_WIDTH = pulse_ctrl_pkg::RESULT_WIDTH,
  parameter int unsigned DROP_W       = pulse_ctrl_pkg::DROP_W
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    init,
  input  logic                    clear_overflow,
  input  logic                    src_req,
  input  logic [RESULT_WIDTH-1:0] src_data,
  input  logic                    grant,
  output logic                    pending,
  output logic [RESULT_WIDTH-1:0] data,
  output logic                    overflow,
  output logic [DROP_W-1:0]       drop_count
);

  logic prev;
  logic rise;
  logic drop;

  assign rise = src_req & ~prev;
  // A grant in the same cycle frees the slot, so the new word replaces it.
  assign drop = rise & pending & ~grant;

  // Request history; tracks the level even during init
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) prev <= 1'b0;
    else         prev <= src_req;
  end

  // Holding register and occupancy flag
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pending <= 1'b0;
      data    <= '0;
    end else if (init) begin
      pending <= 1'b0;
    end else if (rise && !drop) begin
      data    <= src_data;
      pending <= 1'b1;
    end else if (grant) begin
      pending <= 1'b0;
    end
  end

  // Sticky overflow and saturating drop count; a drop beats a clear
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (init) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear_overflow)        drop_count <= DROP_W'(1);
      else if (drop_count != '1) drop_count <= drop_count + 1'b1;
    end else if (clear_overflow) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

endmodule

// File: rtl/result_arbiter.sv
// Round-robin arbiter sharing the rFIFO write port between result sources.
module result_arbiter
  import pulse_ctrl_pkg::*;
#(
  parameter int unsigned N_SRC        = N_RESULT_SRC,
  parameter int unsigned RESULT_WIDTH = pulse_ctrl_pkg::RESULT_WIDTH,
  parameter int unsigned DROP_W       = pulse_ctrl_pkg::DROP_W
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    init,
  input  logic                    clear_overflow,
  result_arbiter_if.slave         bus,
  output logic [N_SRC-1:0]        pending,
  output logic [N_SRC-1:0]        overflow,
  output logic [N_SRC*DROP_W-1:0] drop_count
);

  localparam int unsigned PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  arb_state_t              state, state_nxt;
  logic [PTR_W-1:0]        rr_ptr;
  logic [PTR_W-1:0]        grant_idx;
  logic                    grant_found;
  logic [N_SRC-1:0]        grant_vec;
  logic [RESULT_WIDTH-1:0] slot_data [N_SRC];
  int unsigned             idx;

  for (genvar i = 0; i < N_SRC; i++) begin : g_slot
    result_slot #(
      .RESULT_WIDTH(RESULT_WIDTH),
      .DROP_W      (DROP_W)
    ) u_slot (
      .clock         (clock),
      .resetn        (resetn),
      .init          (init),
      .clear_overflow(clear_overflow),
      .src_req       (bus.src_WrReq[i]),
      .src_data      (bus.src_data[i*RESULT_WIDTH +: RESULT_WIDTH]),
      .grant         (grant_vec[i]),
      .pending       (pending[i]),
      .data          (slot_data[i]),
      .overflow      (overflow[i]),
      .drop_count    (drop_count[i*DROP_W +: DROP_W])
    );
  end

  // First pending slot at or after rr_ptr, searching cyclically
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!grant_found && pending[PTR_W'(idx)]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(idx);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= ARB_IDLE;
    else         state <= state_nxt;
  end

  // Next state and grant decode; init forces IDLE and suppresses grants
  always_comb begin
    state_nxt = state;
    grant_vec = '0;
    case (state)
      ARB_IDLE: begin
        if (grant_found && !bus.rFIFO_full) begin
          grant_vec[grant_idx] = 1'b1;
          state_nxt            = ARB_WRITE;
        end
      end
      ARB_WRITE: state_nxt = ARB_IDLE;
      default:   state_nxt = ARB_IDLE;
    endcase
    if (init) begin
      state_nxt = ARB_IDLE;
      grant_vec = '0;
    end
  end

  // Output registers and round-robin pointer
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bus.rFIFO_WrReq <= 1'b0;
      bus.rFIFO_data  <= '0;
      rr_ptr          <= '0;
    end else if (init) begin
      bus.rFIFO_WrReq <= 1'b0;
      rr_ptr          <= '0;
    end else if (|grant_vec) begin
      bus.rFIFO_WrReq <= 1'b1;
      bus.rFIFO_data  <= slot_data[grant_idx];
      rr_ptr          <= (grant_idx == PTR_W'(N_SRC - 1)) ? '0 : grant_idx + 1'b1;
    end else begin
      bus.rFIFO_WrReq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_result_arbiter.sv
// Bench for result_arbiter: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the arbiter.
module tb_result_arbiter;

  localparam int NS = 3;
  localparam int RW = 32;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic resetn;
  logic init;
  logic clr;
  logic [NS-1:0]    pending;
  logic [NS-1:0]    overflow;
  logic [NS*DW-1:0] drop_count;

  int tests = 0;
  int fails = 0;

  result_arbiter_if #(.N_SRC(NS), .RESULT_WIDTH(RW)) bus ();

  result_arbiter #(.N_SRC(NS), .RESULT_WIDTH(RW), .DROP_W(DW)) dut (
    .clock         (clk),
    .resetn        (resetn),
    .init          (init),
    .clear_overflow(clr),
    .bus           (bus),
    .pending       (pending),
    .overflow      (overflow),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: slots as arrays, one-word-per-two-cycles writer
  bit [RW-1:0] m_data [NS];
  bit          m_pend [NS];
  bit          m_ovf  [NS];
  int          m_cnt  [NS];
  bit          m_prev [NS];
  bit [RW-1:0] m_out;
  bit          m_wr;
  bit          m_busy;
  int          m_rr;
  logic [RW-1:0] wq [$];

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_data[i] = '0; m_pend[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0; m_prev[i] = 0;
    end
    m_out = '0; m_wr = 0; m_busy = 0; m_rr = 0;
  endtask

  task automatic model_update();
    bit rise [NS];
    int g;
    for (int i = 0; i < NS; i++) begin
      rise[i]   = bus.src_WrReq[i] && !m_prev[i];
      m_prev[i] = bus.src_WrReq[i];
    end
    if (init) begin
      for (int i = 0; i < NS; i++) begin
        m_pend[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0;
      end
      m_wr = 0; m_busy = 0; m_rr = 0;
      return;
    end
    g = -1;
    if (!m_busy && !bus.rFIFO_full)
      for (int k = 0; k < NS; k++)
        if (g < 0 && m_pend[(m_rr + k) % NS]) g = (m_rr + k) % NS;
    if (m_busy) begin
      m_wr = 0; m_busy = 0;
    end else if (g >= 0) begin
      m_out = m_data[g]; m_wr = 1; m_busy = 1; m_rr = (g + 1) % NS;
    end
    for (int i = 0; i < NS; i++) begin
      bit drop;
      drop = rise[i] && m_pend[i] && (i != g);
      if (clr) begin m_ovf[i] = 0; m_cnt[i] = 0; end
      if (drop) begin
        m_ovf[i] = 1;
        m_cnt[i] = (m_cnt[i] >= (1 << DW) - 1) ? (1 << DW) - 1 : m_cnt[i] + 1;
      end else if (rise[i]) begin
        m_data[i] = bus.src_data[i*RW +: RW];
        m_pend[i] = 1;
      end else if (i == g) begin
        m_pend[i] = 0;
      end
    end
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [NS-1:0]    ep, eo;
    logic [NS*DW-1:0] ec;
    for (int i = 0; i < NS; i++) begin
      ep[i] = m_pend[i];
      eo[i] = m_ovf[i];
      ec[i*DW +: DW] = DW'(m_cnt[i]);
    end
    chk("wrreq", 64'(bus.rFIFO_WrReq), 64'(m_wr));
    chk("data", 64'(bus.rFIFO_data), 64'(m_out));
    chk("pending", 64'(pending), 64'(ep));
    chk("overflow", 64'(overflow), 64'(eo));
    chk("drop_count", 64'(drop_count), 64'(ec));
  endtask

  task automatic step();
    @(posedge clk);
    if (!resetn) model_reset();
    else         model_update();
    #1;
    check_all();
    if (bus.rFIFO_WrReq === 1'b1) wq.push_back(bus.rFIFO_data);
  endtask

  task automatic set_src(int i, bit r, logic [RW-1:0] d);
    bus.src_WrReq[i]          = r;
    bus.src_data[i*RW +: RW]  = d;
  endtask

  initial begin
    resetn = 1'b0; init = 1'b0; clr = 1'b0;
    bus.src_WrReq = '0; bus.src_data = '0; bus.rFIFO_full = 1'b0;
    model_reset();
    step(); step();
    resetn = 1'b1;

    // 1: single source, one pulse, level held high
    set_src(1, 1, 32'hA5A5_0001);
    wq.delete();
    repeat (6) step();
    chk("t1_count", 64'(wq.size()), 64'd1);
    chk("t1_word", 64'(wq[0]), 64'hA5A5_0001);

    // 2: simultaneous bursts after init (rr_ptr back at 0)
    init = 1'b1; step(); init = 1'b0;
    bus.src_WrReq = '0; step();
    wq.delete();
    set_src(0, 1, 32'h11); set_src(1, 1, 32'h22); set_src(2, 1, 32'h33);
    repeat (8) step();
    chk("t2_count", 64'(wq.size()), 64'd3);
    chk("t2_w0", 64'(wq[0]), 64'h11);
    chk("t2_w1", 64'(wq[1]), 64'h22);
    chk("t2_w2", 64'(wq[2]), 64'h33);
    bus.src_WrReq = '0; step();
    wq.delete();
    set_src(0, 1, 32'h44); set_src(1, 1, 32'h55); set_src(2, 1, 32'h66);
    repeat (8) step();
    chk("t2b_count", 64'(wq.size()), 64'd3);
    chk("t2b_w0", 64'(wq[0]), 64'h44);
    chk("t2b_w1", 64'(wq[1]), 64'h55);
    chk("t2b_w2", 64'(wq[2]), 64'h66);

    // 3: full holds off the pending word
    bus.src_WrReq = '0; step(); step();
    bus.rFIFO_full = 1'b1;
    set_src(0, 1, 32'hC0C0_0000);
    wq.delete();
    repeat (10) step();
    chk("t3_none", 64'(wq.size()), 64'd0);
    chk("t3_pend", 64'(pending[0]), 64'd1);
    bus.rFIFO_full = 1'b0;
    step();
    chk("t3_pulse", 64'(bus.rFIFO_WrReq), 64'd1);
    chk("t3_clear", 64'(pending[0]), 64'd0);
    step(); step();
    chk("t3_count", 64'(wq.size()), 64'd1);

    // 4: second word on src2 dropped while full
    bus.src_WrReq = '0; step();
    bus.rFIFO_full = 1'b1;
    set_src(2, 1, 32'h2001); step();
    set_src(2, 0, 32'h0);    step(); step(); step();
    set_src(2, 1, 32'h2002); step();
    set_src(2, 0, 32'h0);    step();
    chk("t4_ovf", 64'(overflow[2]), 64'd1);
    chk("t4_cnt", 64'(drop_count[2*DW +: DW]), 64'd1);
    bus.rFIFO_full = 1'b0;
    wq.delete();
    repeat (4) step();
    chk("t4_count", 64'(wq.size()), 64'd1);
    chk("t4_word", 64'(wq[0]), 64'h2001);
    clr = 1'b1; step(); clr = 1'b0;
    chk("t4_ovf_clr", 64'(overflow), 64'd0);
    chk("t4_cnt_clr", 64'(drop_count), 64'd0);

    // 5: new edge on src0 in the very cycle slot 0 is granted
    step();
    bus.rFIFO_full = 1'b1;
    set_src(0, 1, 32'h5001); step();
    set_src(0, 0, 32'h0);    step();
    set_src(0, 1, 32'h5002);
    bus.rFIFO_full = 1'b0;
    wq.delete();
    step();
    set_src(0, 0, 32'h0);
    repeat (5) step();
    chk("t5_count", 64'(wq.size()), 64'd2);
    chk("t5_w0", 64'(wq[0]), 64'h5001);
    chk("t5_w1", 64'(wq[1]), 64'h5002);
    chk("t5_ovf", 64'(overflow), 64'd0);

    // 6: init with two slots pending, then async reset during WRITE
    bus.rFIFO_full = 1'b1;
    set_src(0, 1, 32'h6001); set_src(1, 1, 32'h6002);
    step(); step();
    chk("t6_pend", 64'(pending), 64'd3);
    init = 1'b1; bus.rFIFO_full = 1'b0;
    step();
    init = 1'b0;
    chk("t6_wr", 64'(bus.rFIFO_WrReq), 64'd0);
    chk("t6_pend0", 64'(pending), 64'd0);
    wq.delete();
    repeat (4) step();
    chk("t6_nofire", 64'(wq.size()), 64'd0);
    bus.src_WrReq = '0; step();
    set_src(0, 1, 32'h7001); step(); step();
    chk("t6_write", 64'(bus.rFIFO_WrReq), 64'd1);
    #2 resetn = 1'b0;
    #1;
    chk("t6_rst_wr", 64'(bus.rFIFO_WrReq), 64'd0);
    chk("t6_rst_data", 64'(bus.rFIFO_data), 64'd0);
    chk("t6_rst_pend", 64'(pending), 64'd0);
    model_reset();
    step();
    resetn = 1'b1;

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NS; i++)
        if ($urandom_range(2) == 0)
          set_src(i, !bus.src_WrReq[i], RW'($urandom()));
      bus.rFIFO_full = ($urandom_range(3) == 0);
      clr            = ($urandom_range(19) == 0);
      init           = ($urandom_range(59) == 0);
      step();
    end
    init = 1'b0; clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
